// File: rtl/id_ex_if.sv
// ID/EX bundle: decode-side operands/controls in,
// execute-side registered copies out.
interface id_ex_if #(
  parameter int WIDTH = 32
);
  logic             validD;
  logic             regwriteD;
  logic             memtoregD;
  logic             memwriteD;
  logic             alusrcD;
  logic             regdstD;
  logic [2:0]       alucontrolD;
  logic [WIDTH-1:0] rd1D;
  logic [WIDTH-1:0] rd2D;
  logic [4:0]       rsD;
  logic [4:0]       rtD;
  logic [4:0]       rdD;
  logic [WIDTH-1:0] signimmD;
  logic [WIDTH-1:0] pcplus4D;

  logic             validE;
  logic             regwriteE;
  logic             memtoregE;
  logic             memwriteE;
  logic             alusrcE;
  logic             regdstE;
  logic [2:0]       alucontrolE;
  logic [WIDTH-1:0] rd1E;
  logic [WIDTH-1:0] rd2E;
  logic [4:0]       rsE;
  logic [4:0]       rtE;
  logic [4:0]       rdE;
  logic [WIDTH-1:0] signimmE;
  logic [WIDTH-1:0] pcplus4E;

  modport master (
    output validD, regwriteD, memtoregD,
    output memwriteD, alusrcD, regdstD,
    output alucontrolD, rd1D, rd2D,
    output rsD, rtD, rdD, signimmD, pcplus4D,
    input  validE, regwriteE, memtoregE,
    input  memwriteE, alusrcE, regdstE,
    input  alucontrolE, rd1E, rd2E,
    input  rsE, rtE, rdE, signimmE, pcplus4E
  );

  modport slave (
    input  validD, regwriteD, memtoregD,
    input  memwriteD, alusrcD, regdstD,
    input  alucontrolD, rd1D, rd2D,
    input  rsD, rtD, rdD, signimmD, pcplus4D,
    output validE, regwriteE, memtoregE,
    output memwriteE, alusrcE, regdstE,
    output alucontrolE, rd1E, rd2E,
    output rsE, rtE, rdE, signimmE, pcplus4E
  );
endinterface

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with stall, flush,
// valid tracking and a saturating bubble counter.
module id_ex_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             stallE,
  input  logic             flushE,
  id_ex_if.slave           bus,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic             valid_q;
  logic             regwrite_q;
  logic             memtoreg_q;
  logic             memwrite_q;
  logic             alusrc_q;
  logic             regdst_q;
  logic [2:0]       aluctl_q;
  logic [WIDTH-1:0] rd1_q;
  logic [WIDTH-1:0] rd2_q;
  logic [4:0]       rs_q;
  logic [4:0]       rt_q;
  logic [4:0]       rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] pc4_q;
  logic [CNT_W-1:0] cnt_q;

  logic load;
  logic bubble;

  assign load   = !flushE && !stallE;
  assign bubble = flushE || (load && !bus.validD);

  // Controls and valid: cleared on flush or an invalid slot
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      aluctl_q   <= 3'b000;
    end else if (flushE || (load && !bus.validD)) begin
      valid_q    <= 1'b0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      memwrite_q <= 1'b0;
      alusrc_q   <= 1'b0;
      regdst_q   <= 1'b0;
      aluctl_q   <= 3'b000;
    end else if (load) begin
      valid_q    <= 1'b1;
      regwrite_q <= bus.regwriteD;
      memtoreg_q <= bus.memtoregD;
      memwrite_q <= bus.memwriteD;
      alusrc_q   <= bus.alusrcD;
      regdst_q   <= bus.regdstD;
      aluctl_q   <= bus.alucontrolD;
    end
  end

  // Operands and specifiers: cleared on flush, else loaded
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      pc4_q <= '0;
    end else if (flushE) begin
      rd1_q <= '0;
      rd2_q <= '0;
      rs_q  <= '0;
      rt_q  <= '0;
      rd_q  <= '0;
      imm_q <= '0;
      pc4_q <= '0;
    end else if (load) begin
      rd1_q <= bus.rd1D;
      rd2_q <= bus.rd2D;
      rs_q  <= bus.rsD;
      rt_q  <= bus.rtD;
      rd_q  <= bus.rdD;
      imm_q <= bus.signimmD;
      pc4_q <= bus.pcplus4D;
    end
  end

  // Bubble counter: counts inserted bubbles, sticks at max
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else if (bubble && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.validE      = valid_q;
  assign bus.regwriteE   = regwrite_q;
  assign bus.memtoregE   = memtoreg_q;
  assign bus.memwriteE   = memwrite_q;
  assign bus.alusrcE     = alusrc_q;
  assign bus.regdstE     = regdst_q;
  assign bus.alucontrolE = aluctl_q;
  assign bus.rd1E        = rd1_q;
  assign bus.rd2E        = rd2_q;
  assign bus.rsE         = rs_q;
  assign bus.rtE         = rt_q;
  assign bus.rdE         = rd_q;
  assign bus.signimmE    = imm_q;
  assign bus.pcplus4E    = pc4_q;
  assign bubble_cnt      = cnt_q;

endmodule
